exec_wb_queue: RTL and testbench
================================

# exec_wb_queue

Parametrised execute-to-writeback decoupling queue with an integrated architectural flags register; the next-generation replacement for the single-entry execute pipestage. Buffers up to DEPTH execute results, so short writeback stalls no longer back-pressure the ALU. Commits flag updates only on an accepted handshake; an execute result that is presented but not accepted never changes the flags. Sits between the ALU/branch logic and writeback, and is cleared by the pipeline flush.

## Interface
- WIDTH, 200: bits per entry; opaque packed writeback payload.
- DEPTH, 4: number of entries; power of two, minimum 2.
- FLAG_W, 7: flags register width; bit FLAG_W-1 is DF.
- FLAG_RST, 7'h00: reset value of the flags register.
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- flush  in  1  discards every queued entry.
- in_valid  in  1  execute has a result.
- in_ready  out  1  queue accepts this cycle.
- in_data  in  WIDTH  payload.
- in_flags  in  FLAG_W  new flag values.
- in_flag_mask  in  FLAG_W  per-bit write enable for in_flags.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  writeback consumes the head entry.
- out_data  out  WIDTH  head payload.
- flags_out  out  FLAG_W  current flags; the ALU reads these.
- count  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Accept occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready.
- in_ready = (count != DEPTH) & ~flush. There is no combinational path from out_ready to in_ready, so a full queue stalls for one cycle even when it pops.
- Storage is a circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH. count is a separate register.
- Accept and pop in the same cycle: count is unchanged and both pointers advance.
- flags_out update on accept: flags <= (flags & ~in_flag_mask) | (in_flags & in_flag_mask). With no accept, flags hold their value.
- flush: count, rd_ptr and wr_ptr go to 0 on the next edge and out_valid drops. Flags are NOT altered. No accept occurs in the flush cycle because in_ready is 0. A pop in the same cycle is ignored.
- reset: count=0, pointers=0, out_valid=0, flags_out=FLAG_RST, in_ready=1 (once reset deasserts). out_data is undefined while out_valid=0.
- Assertion of reset mid-transfer takes effect immediately and discards all entries.

## Timing
- Without bypass, latency from accept to out_valid is 1 cycle.
- out_valid = (count != 0), driven from registers.
- out_data is read combinationally from the head entry, so it is stable while out_valid=1 and out_ready=0.
- flags_out changes at the edge following an accept. A dependent instruction sees the updated flags in the next cycle.
- Throughput is one entry per cycle while 0 < count < DEPTH.

## Configuration
- EXEC_WB_BYPASS_EN defined: when count==0, in_valid=1 and out_ready=1, the payload passes straight through. out_valid=in_valid and out_data=in_data in the same cycle, nothing is written, and latency is 0. Flags still update on the accept.
- EXEC_WB_BYPASS_EN undefined: bypass logic is removed and latency is always 1 cycle.

## Structure
- Package exec_wb_pkg holds:
  - Default WIDTH/DEPTH/FLAG_W.
  - Flag bit indices: CF=0, PF=1, AF=2, ZF=3, SF=4, OF=5, DF=6.
  - A packed typedef for the writeback payload fields.
- Sub-module exec_wb_flags_reg holds the masked-write flags register with async reset. It takes clk, reset, we, din, mask and dout.
- Queue storage is an inline register array; it has no separate module.

## Test plan
- Reset, then push 4 entries 'h11..'h14 with out_ready=0 -> count=4, in_ready=0, out_valid=1, out_data='h11.
- Full queue, out_ready=1 for 4 cycles -> pops 'h11,'h12,'h13,'h14 in order; count reaches 0; in_ready returns to 1 the cycle after the first pop.
- Continuous push+pop for 10 cycles at count=2 -> count stays 2, data order is preserved across pointer wrap, nothing is lost or duplicated.
- Flags: start at 0x00; accept with in_flags=0x7F, mask=0x09 -> flags_out=0x09. Then in_valid with in_ready=0 (full) and mask=0x7F -> flags_out stays 0x09.
- Flush with count=3 while in_valid=1 -> next cycle count=0, out_valid=0, flags unchanged, in_data not enqueued.
- Async reset asserted mid-cycle with count=2 -> count=0 and flags_out=FLAG_RST without waiting for a clock edge. Under EXEC_WB_BYPASS_EN, an empty queue with in_valid=1 and out_ready=1 -> out_data=in_data in the same cycle and count stays 0.

Source files
------------

// File: rtl/exec_wb_pkg.sv
// exec_wb_pkg: shared defaults, flag bit indices and writeback payload layout for exec_wb_queue.
package exec_wb_pkg;
    localparam int DEF_WIDTH  = 200;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_FLAG_W = 7;

    localparam int CF = 0;
    localparam int PF = 1;
    localparam int AF = 2;
    localparam int ZF = 3;
    localparam int SF = 4;
    localparam int OF = 5;
    localparam int DF = 6;

    typedef struct packed {
        logic [7:0]  rd_tag;
        logic [63:0] result;
        logic [63:0] pc;
        logic [63:0] mem_addr;
    } wb_payload_t;
endpackage

// File: rtl/exec_wb_flags_reg.sv
// exec_wb_flags_reg: architectural flags register; only bits selected by mask are written when we is high.
module exec_wb_flags_reg #(
    parameter int W = 7,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [W-1:0] din,
    input  logic [W-1:0] mask,
    output logic [W-1:0] dout
);
    always_ff @(posedge clk or posedge reset)
        if (reset)
            dout <= RST;
        else if (we)
            dout <= (dout & ~mask) | (din & mask);
endmodule

// File: rtl/exec_wb_queue.sv
// exec_wb_queue: execute-to-writeback circular queue with masked flags commit on accept.
// Define EXEC_WB_BYPASS_EN to let an empty queue pass the payload straight through in the same cycle.
module exec_wb_queue import exec_wb_pkg::*; #(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int FLAG_W = DEF_FLAG_W,
    parameter logic [FLAG_W-1:0] FLAG_RST = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [FLAG_W-1:0]        in_flags,
    input  logic [FLAG_W-1:0]        in_flag_mask,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [FLAG_W-1:0]        flags_out,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             byp, accept, push, pop, empty;

    assign empty = (count == '0);
`ifdef EXEC_WB_BYPASS_EN
    assign byp = empty & in_valid & out_ready & ~flush;
`else
    assign byp = 1'b0;
`endif
    // in_ready deliberately ignores out_ready so no combinational path crosses the queue
    assign in_ready  = (count != CW'(DEPTH)) & ~flush;
    assign accept    = in_valid & in_ready;
    assign push      = accept & ~byp;
    assign pop       = ~empty & out_ready;
    assign out_valid = ~empty | byp;
    assign out_data  = byp ? in_data : mem[rd_ptr];

    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= in_data;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end

    exec_wb_flags_reg #(.W(FLAG_W), .RST(FLAG_RST)) u_flags (
        .clk   (clk),
        .reset (reset),
        .we    (accept),
        .din   (in_flags),
        .mask  (in_flag_mask),
        .dout  (flags_out)
    );
endmodule

// File: tb/tb_exec_wb_queue.sv
// tb_exec_wb_queue: directed stimulus with a queue-based reference model checked every cycle.
module tb_exec_wb_queue;
    localparam int W = 200;
    localparam int D = 4;
    localparam int F = 7;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [F-1:0] in_flags = '0;
    logic [F-1:0] in_flag_mask = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [F-1:0] flags_out;
    logic [2:0]   count;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] mq[$];
    logic [F-1:0] mflags;

    exec_wb_queue #(.WIDTH(W), .DEPTH(D), .FLAG_W(F), .FLAG_RST(7'h00)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_flags(in_flags), .in_flag_mask(in_flag_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flags_out(flags_out), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_byp();
`ifdef EXEC_WB_BYPASS_EN
        return mq.size() == 0 && in_valid && out_ready && !flush;
`else
        return 1'b0;
`endif
    endfunction

    // reference: a plain FIFO plus masked flags, advanced once per edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            mflags = 7'h00;
        end else begin
            logic rdy, acc, b, p;
            rdy = (mq.size() != D) && !flush;
            acc = in_valid && rdy;
            b   = model_byp();
            p   = (mq.size() != 0) && out_ready;
            if (acc)
                mflags = (mflags & ~in_flag_mask) | (in_flags & in_flag_mask);
            if (flush)
                mq.delete();
            else begin
                if (p)
                    void'(mq.pop_front());
                if (acc && !b)
                    mq.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            logic b;
            b = model_byp();
            chk("m_count", 256'(count), 256'(mq.size()));
            chk("m_in_ready", 256'(in_ready), 256'((mq.size() != D) && !flush));
            chk("m_out_valid", 256'(out_valid), 256'(mq.size() != 0 || b));
            chk("m_flags", 256'(flags_out), 256'(mflags));
            if (b)
                chk("m_out_data_byp", 256'(out_data), 256'(in_data));
            else if (mq.size() != 0)
                chk("m_out_data", 256'(out_data), 256'(mq[0]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "timeout");
    end

    initial begin
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("rst_count", 256'(count), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_flags", 256'(flags_out), 256'(7'h00));
        cyc();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = W'(8'h11 + i);
            in_flags = (i == 0) ? 7'h7F : 7'h00;
            in_flag_mask = (i == 0) ? 7'h09 : 7'h00;
            cyc();
        end
        in_valid = 1'b0;
        #1;
        chk("full_count", 256'(count), 256'(4));
        chk("full_in_ready", 256'(in_ready), 256'(0));
        chk("full_out_valid", 256'(out_valid), 256'(1));
        chk("full_head", 256'(out_data), 256'(8'h11));
        chk("flags_masked", 256'(flags_out), 256'(7'h09));
        in_valid = 1'b1;
        in_data = W'(8'h99);
        in_flags = 7'h7F;
        in_flag_mask = 7'h7F;
        cyc();
        in_valid = 1'b0;
        in_flag_mask = 7'h00;
        #1;
        chk("flags_no_accept", 256'(flags_out), 256'(7'h09));
        chk("full_hold_count", 256'(count), 256'(4));
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b1;
            #1;
            chk("pop_order", 256'(out_data), 256'(8'h11 + i));
            cyc();
            if (i == 0)
                chk("ready_after_pop", 256'(in_ready), 256'(1));
        end
        out_ready = 1'b0;
        #1;
        chk("drain_count", 256'(count), 256'(0));
        chk("drain_out_valid", 256'(out_valid), 256'(0));
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data = W'(8'h20 + i);
            cyc();
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data = W'(8'h22 + i);
            out_ready = 1'b1;
            #1;
            chk("stream_data", 256'(out_data), 256'(8'h20 + i));
            chk("stream_count", 256'(count), 256'(2));
            cyc();
        end
        out_ready = 1'b0;
        in_data = W'(8'h40);
        cyc();
        in_valid = 1'b1;
        flush = 1'b1;
        in_data = W'(8'h55);
        in_flags = 7'h7F;
        in_flag_mask = 7'h7F;
        #1;
        chk("pre_flush_count", 256'(count), 256'(3));
        chk("flush_in_ready", 256'(in_ready), 256'(0));
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        in_flag_mask = 7'h00;
        #1;
        chk("flush_count", 256'(count), 256'(0));
        chk("flush_out_valid", 256'(out_valid), 256'(0));
        chk("flush_flags", 256'(flags_out), 256'(7'h09));
        in_valid = 1'b1;
        in_data = W'(8'h60);
        in_flags = 7'h7F;
        in_flag_mask = 7'h7F;
        cyc();
        in_data = W'(8'h61);
        in_flag_mask = 7'h00;
        cyc();
        in_valid = 1'b0;
        #1;
        chk("pre_rst_count", 256'(count), 256'(2));
        chk("pre_rst_flags", 256'(flags_out), 256'(7'h7F));
        chk("pre_rst_head", 256'(out_data), 256'(8'h60));
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_count", 256'(count), 256'(0));
        chk("async_rst_flags", 256'(flags_out), 256'(7'h00));
        chk("async_rst_out_valid", 256'(out_valid), 256'(0));
        cyc();
        reset = 1'b0;
        cyc();
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_data = W'(8'hAB);
        in_flags = 7'h01;
        in_flag_mask = 7'h01;
        #1;
`ifdef EXEC_WB_BYPASS_EN
        chk("byp_out_valid", 256'(out_valid), 256'(1));
        chk("byp_out_data", 256'(out_data), 256'(8'hAB));
`else
        chk("nobyp_out_valid", 256'(out_valid), 256'(0));
`endif
        cyc();
        in_valid = 1'b0;
        in_flag_mask = 7'h00;
        #1;
        chk("byp_flags", 256'(flags_out), 256'(7'h01));
`ifdef EXEC_WB_BYPASS_EN
        chk("byp_count", 256'(count), 256'(0));
`else
        chk("nobyp_count", 256'(count), 256'(1));
        chk("nobyp_out_data", 256'(out_data), 256'(8'hAB));
`endif
        cyc();
        out_ready = 1'b0;
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
